// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime baud, parity and stop-bit selection. It takes a 3-sample majority
// vote at each bit centre, flags parity/framing/overrun errors and hands words out on valid/ready.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PERIOD_BASE = 100
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic [2:0]           i_baud,
  input  logic [1:0]           i_parity,
  input  logic                 i_stop2,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int CW = $clog2(PERIOD_BASE * 48 + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        per, half, c, c_nxt;
  logic [1:0]           par_cfg;
  logic                 stop2_q;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic                 samp_a, samp_b;
  logic                 bit_val, decide, bit_end, complete, parity_on;
  logic                 perr, ferr;
  logic [DATA_BITS-1:0] shreg;

  function automatic logic [CW-1:0] period_of(input logic [2:0] baud);
    int mult;
    mult = 48;
    case (baud)
      3'd0:    mult = 1;
      3'd1:    mult = 2;
      3'd2:    mult = 4;
      3'd3:    mult = 6;
      3'd4:    mult = 12;
      3'd5:    mult = 24;
      default: mult = 48;
    endcase
    return CW'(PERIOD_BASE * mult);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic x);
    return (a & b) | (a & x) | (b & x);
  endfunction

  assign half      = per >> 1;
  assign decide    = (c == half + CW'(1));
  assign bit_end   = (c == per - CW'(1));
  assign bit_val   = maj3(samp_a, samp_b, rxs);
  assign parity_on = (par_cfg == 2'd1) || (par_cfg == 2'd2);
  assign o_busy    = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    c_nxt       = c + CW'(1);
    bit_cnt_nxt = bit_cnt;
    complete    = 1'b0;
    case (state)
      // c starts at 1: the cycle that saw the line low is bit time 0
      S_IDLE: begin
        c_nxt = CW'(1);
        if (rxs) c_nxt = '0;
        else     state_nxt = S_START;
      end
      S_START: begin
        if (decide && bit_val) begin
          state_nxt = S_IDLE;
          c_nxt     = '0;
        end else if (bit_end) begin
          state_nxt   = S_DATA;
          c_nxt       = '0;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          c_nxt = '0;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = parity_on ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          c_nxt       = '0;
          bit_cnt_nxt = '0;
          state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (decide && bit_cnt == {3'b000, stop2_q}) begin
          complete  = 1'b1;
          c_nxt     = '0;
          state_nxt = (ferr || !bit_val) ? S_BREAK : S_IDLE;
        end else if (bit_end) begin
          c_nxt       = '0;
          bit_cnt_nxt = bit_cnt + 4'd1;
        end
      end
      // a held-low line keeps restarting the high-time count
      S_BREAK: begin
        if (!rxs) begin
          c_nxt = '0;
        end else if (bit_end) begin
          c_nxt     = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= S_IDLE;
      c       <= '0;
      bit_cnt <= '0;
      per     <= '0;
      par_cfg <= '0;
      stop2_q <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
      state   <= state_nxt;
      c       <= c_nxt;
      bit_cnt <= bit_cnt_nxt;
      if (state == S_IDLE) begin
        perr <= 1'b0;
        ferr <= 1'b0;
        if (!rxs) begin
          per     <= period_of(i_baud);
          par_cfg <= i_parity;
          stop2_q <= i_stop2;
        end
      end
      if (state == S_PARITY && decide)
        perr <= (par_cfg == 2'd1) ? ~(^shreg ^ bit_val) : (^shreg ^ bit_val);
      if (state == S_STOP && decide && !bit_val)
        ferr <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (c == half - CW'(1)) samp_a <= rxs;
    if (c == half)          samp_b <= rxs;
    if (state == S_DATA && decide) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
  end

  // output holding register; a completion in the accept cycle replaces the word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (complete) begin
        if (!o_valid || i_ready) begin
          o_valid      <= 1'b1;
          o_data       <= shreg;
          o_parity_err <= perr;
          o_frame_err  <= ferr | ~bit_val;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid      <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed scenarios plus randomized frames scored against a
// frame-level reference model (parity by bit count, framing by stop-bit values).
module tb_uart_rx_cfg;
  localparam int PB = 100;

  logic       clk = 1'b0;
  logic       rst, rx, ready, stop2;
  logic [2:0] baud;
  logic [1:0] parity;
  logic [7:0] data;
  logic       valid, perr, ferr, ovr, busy;
  logic       rnd_on = 1'b0, rnd_rdy = 1'b1, ready_in;

  logic       rst2, rx2, ready2, stop2_2;
  logic [2:0] baud2;
  logic [1:0] parity2;
  logic [6:0] data2;
  logic       valid2, perr2, ferr2, ovr2, busy2;

  assign ready_in = rnd_on ? rnd_rdy : ready;

  uart_rx_cfg #(.DATA_BITS(8), .PERIOD_BASE(PB)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_baud(baud), .i_parity(parity), .i_stop2(stop2),
    .i_ready(ready_in), .o_data(data), .o_valid(valid), .o_parity_err(perr),
    .o_frame_err(ferr), .o_overrun(ovr), .o_busy(busy));

  uart_rx_cfg #(.DATA_BITS(7), .PERIOD_BASE(PB)) dut7 (
    .i_clk(clk), .i_rst(rst2), .i_rx(rx2), .i_baud(baud2), .i_parity(parity2), .i_stop2(stop2_2),
    .i_ready(ready2), .o_data(data2), .o_valid(valid2), .o_parity_err(perr2),
    .o_frame_err(ferr2), .o_overrun(ovr2), .o_busy(busy2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // reference model: one entry per word the consumer must see, in order
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic model_perr(input int mode, input logic [8:0] d, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (mode == 1) return (ones % 2) != 1;
    if (mode == 2) return (ones % 2) != 0;
    return 1'b0;
  endfunction

  task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    exp_q.push_back(e);
  endtask

  // monitor for the 8-bit receiver
  bit mon_on = 1'b0;
  int last_rise = 0, rises = 0, run = 0, last_len = 0, ovr_cnt = 0;
  logic vprev = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (mon_on) begin
      if (valid && !vprev) begin last_rise = cyc; rises++; end
      if (valid) run++;
      else if (run > 0) begin last_len = run; run = 0; end
      vprev = valid;
      if (ovr) ovr_cnt++;
      if (valid && ready_in) begin
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", 32'(data), 32'(e.d));
          check("word_perr", 32'(perr), 32'(e.pe));
          check("word_ferr", 32'(ferr), 32'(e.fe));
        end
      end
    end
  end

  always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycles=%0d limit=95000", cyc);
    $fatal(1, "watchdog");
  end

  int start_cyc = 0;

  task automatic set_line(input int which, input logic v);
    if (which == 1) rx = v; else rx2 = v;
  endtask

  task automatic hold(input int which, input logic v, input int n);
    repeat (n) begin @(negedge clk); set_line(which, v); end
  endtask

  task automatic send(input int which, input int p, input int nb, input logic [8:0] d,
                      input int mode, input logic pbit, input logic two, input logic s1,
                      input logic s2, input int gl_bit, input int gl_off, input bit scramble);
    logic fr[$];
    logic v;
    fr.push_back(1'b0);
    for (int i = 0; i < nb; i++) fr.push_back(d[i]);
    if (mode == 1 || mode == 2) fr.push_back(pbit);
    fr.push_back(s1);
    if (two) fr.push_back(s2);
    for (int b = 0; b < fr.size(); b++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        if (b == 0 && j == 0) start_cyc = cyc;
        if (scramble && which == 1 && b == 1 && j == 0) begin
          baud = 3'($urandom_range(0, 7)); parity = 2'($urandom_range(0, 3));
          stop2 = 1'($urandom_range(0, 1));
        end
        v = fr[b];
        if (b == gl_bit && j == gl_off) v = ~v;
        set_line(which, v);
      end
    end
  endtask

  initial begin
    int r0, o0, diff, lat_exp;
    rx = 1'b1; rx2 = 1'b1; ready = 1'b1; ready2 = 1'b0;
    baud = 3'd0; parity = 2'd0; stop2 = 1'b0;
    baud2 = 3'd0; parity2 = 2'd0; stop2_2 = 1'b0;
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_data", 32'(data), 0);
    check("rst_perr", 32'(perr), 0);
    check("rst_ferr", 32'(ferr), 0);
    check("rst_overrun", 32'(ovr), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0; mon_on = 1'b1;
    hold(1, 1'b1, 5);

    // 8N1 word, latency and single-cycle valid
    expect_word(8'hA5, 1'b0, 1'b0);
    send(1, PB, 8, 9'h0A5, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(1, 1'b1, 20);
    diff = last_rise - start_cyc;
    lat_exp = 2 + 9 * PB + PB / 2 + 2;
    check($sformatf("t1_latency_%0d_vs_%0d", diff, lat_exp),
          32'(diff >= lat_exp - 1 && diff <= lat_exp + 1), 1);
    check("t1_valid_len", 32'(last_len), 1);

    // even parity, wrong then right parity bit
    parity = 2'd2;
    expect_word(8'h03, model_perr(2, 9'h003, 1'b1), 1'b0);
    send(1, PB, 8, 9'h003, 2, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(1, 1'b1, 20);
    expect_word(8'h03, model_perr(2, 9'h003, 1'b0), 1'b0);
    send(1, PB, 8, 9'h003, 2, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(1, 1'b1, 20);
    check("t2_drained", 32'(exp_q.size()), 0);

    // bad second stop bit then held-low line
    parity = 2'd0; stop2 = 1'b1;
    r0 = rises;
    expect_word(8'h5A, 1'b0, 1'b1);
    send(1, PB, 8, 9'h05A, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
    hold(1, 1'b0, 3 * PB);
    #1 check("t3_busy_low", 32'(busy), 1);
    hold(1, 1'b1, PB / 2);
    #1 check("t3_break_holds", 32'(busy), 1);
    hold(1, 1'b1, PB / 2 + 10);
    #1 check("t3_break_exit", 32'(busy), 0);
    check("t3_one_word", 32'(rises - r0), 1);
    expect_word(8'h11, 1'b0, 1'b0);
    send(1, PB, 8, 9'h011, 0, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(1, 1'b1, 20);
    check("t3_drained", 32'(exp_q.size()), 0);

    // 30-clock glitch on idle line
    stop2 = 1'b0;
    r0 = rises;
    hold(1, 1'b0, 20);
    #1 check("t4_busy_during", 32'(busy), 1);
    hold(1, 1'b0, 10);
    hold(1, 1'b1, 100);
    #1 check("t4_idle_after", 32'(busy), 0);
    check("t4_no_word", 32'(rises - r0), 0);

    // randomized frames: config, glitches inside the vote window, mid-frame config changes
    o0 = ovr_cnt;
    rnd_on = 1'b1;
    for (int n = 0; n < 10; n++) begin
      int psel, p, mode, glb, glo;
      logic [8:0] d;
      logic pbit, two, s1, s2;
      psel = $urandom_range(0, 1);
      p = PB * (psel + 1);
      mode = $urandom_range(0, 3);
      two = 1'($urandom_range(0, 1));
      d = 9'($urandom_range(0, 255));
      pbit = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      glb = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 8) : -1;
      glo = p / 2 - 1 + $urandom_range(0, 2);
      baud = 3'(psel); parity = 2'(mode); stop2 = two;
      expect_word(d[7:0], model_perr(mode, d, pbit), !s1 || (two && !s2));
      send(1, p, 8, d, mode, pbit, two, s1, s2, glb, glo, 1'b1);
      hold(1, 1'b1, p + 10 + $urandom_range(0, 20));
    end
    rnd_on = 1'b0;
    hold(1, 1'b1, 5);
    check("rnd_drained", 32'(exp_q.size()), 0);
    check("rnd_no_overrun", 32'(ovr_cnt - o0), 0);

    // overrun while the consumer stalls
    baud = 3'd0; parity = 2'd0; stop2 = 1'b0; ready = 1'b0;
    o0 = ovr_cnt;
    expect_word(8'h01, 1'b0, 1'b0);
    send(1, PB, 8, 9'h001, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(1, 1'b1, 20);
    send(1, PB, 8, 9'h002, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(1, 1'b1, 20);
    #1;
    check("t5_valid_held", 32'(valid), 1);
    check("t5_data_kept", 32'(data), 32'h01);
    check("t5_overrun_pulse", 32'(ovr_cnt - o0), 1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    #1 check("t5_valid_drop", 32'(valid), 0);
    check("t5_drained", 32'(exp_q.size()), 0);

    // 7-bit receiver: reset in the middle of data bit 3 at the x24 rate
    send(2, PB, 7, 9'h02A, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(2, 1'b1, 20);
    #1;
    check("t6_pre_valid", 32'(valid2), 1);
    check("t6_pre_data", 32'(data2), 32'h2A);
    baud2 = 3'd5;
    hold(2, 1'b0, 24 * PB);
    hold(2, 1'b1, 24 * PB);
    hold(2, 1'b0, 24 * PB);
    hold(2, 1'b1, 24 * PB);
    hold(2, 1'b0, 12 * PB);
    #1 check("t6_busy_mid", 32'(busy2), 1);
    rst2 = 1'b1;
    #1;
    check("t6_rst_valid", 32'(valid2), 0);
    check("t6_rst_data", 32'(data2), 0);
    check("t6_rst_perr", 32'(perr2), 0);
    check("t6_rst_ferr", 32'(ferr2), 0);
    check("t6_rst_overrun", 32'(ovr2), 0);
    check("t6_rst_busy", 32'(busy2), 0);
    hold(2, 1'b1, 5);
    rst2 = 1'b0;
    hold(2, 1'b1, 20);
    send(2, 24 * PB, 7, 9'h07F, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
    hold(2, 1'b1, 20);
    #1;
    check("t6_valid", 32'(valid2), 1);
    check("t6_data", 32'(data2), 32'h7F);
    check("t6_perr", 32'(perr2), 0);
    check("t6_ferr", 32'(ferr2), 0);
    check("t6_idle", 32'(busy2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
